// File: rtl/bitwise_logic_seq.sv
// Multi-cycle bitwise AND/OR/XOR/NOR unit: processes SLICE bits per clock,
// LSB slice first, and publishes result/zero only on the completion edge.
module bitwise_logic_seq #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   localparam int N  = WIDTH / SLICE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   logic [0:0]       state_q;
   logic [CW-1:0]    cnt_q;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH-1:0] work_q, work_d;
   logic [WIDTH-1:0] result_q;
   logic             zero_q, done_q;
   logic [WIDTH-1:0] fw;
   logic             last;

   // Full-width function of the captured operands; only the active slice is kept.
   always_comb begin
      fw = '0;
      case (op_q)
         2'b00:   fw = a_q & b_q;
         2'b01:   fw = a_q | b_q;
         2'b10:   fw = a_q ^ b_q;
         default: fw = ~(a_q | b_q);
      endcase
   end

   always_comb begin
      work_d = work_q;
      for (int i = 0; i < N; i++) begin
         if (cnt_q == CW'(i)) work_d[i*SLICE +: SLICE] = fw[i*SLICE +: SLICE];
      end
   end

   assign last = (state_q == S_BUSY) && (cnt_q == CNT_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         work_q   <= '0;
         result_q <= '0;
         zero_q   <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  op_q    <= op;
                  work_q  <= '0;
                  cnt_q   <= '0;
                  state_q <= S_BUSY;
               end
            end
            S_BUSY: begin
               work_q <= work_d;
               if (last) begin
                  result_q <= work_d;
                  zero_q   <= (work_d == '0);
                  done_q   <= 1'b1;
                  cnt_q    <= '0;
                  state_q  <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy   = (state_q == S_BUSY);
   assign done   = done_q;
   assign result = result_q;
   assign zero   = zero_q;

endmodule
